stage_id_pipe: RTL and testbench

- Parametrised instruction-decode stage with an integrated ID/EX pipeline register, for the 5-stage MIPS-subset pipeline.
- Decodes the IF/ID instruction and reads an internal register file, with write-through bypass from the WR stage.
- Detects load-use hazards against the instruction currently in EX, and drives stall/bubble.
- Registers all decoded fields and control into the EX stage, with flush and hold support.

---
 rtl/stage_id_pipe.sv | 105 ++++++++++
 tb/tb_stage_id_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_id_pipe.sv
// stage_id_pipe: MIPS-subset decode stage with register file, WR bypass, load-use hazard detection and ID/EX register
// Ports: Clk/Rst (sync, active-high); IDin_PC4/IDin_Inst/IDin_Valid from IF/ID;
//        WR_RegWE/WR_Rw/WR_RegDin register write-back; Flush squashes ID, Hold freezes ID/EX;
//        Stall (combinational) freezes PC and IF/ID; EX_* are the registered ID/EX fields.
module stage_id_pipe #(
    parameter int DATA_W    = 32,
    parameter int AW        = 5,
    parameter int BYPASS_EN = 1,
    parameter int HAZARD_EN = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [31:0]       IDin_PC4,
    input  logic [31:0]       IDin_Inst,
    input  logic              IDin_Valid,
    input  logic              WR_RegWE,
    input  logic [AW-1:0]     WR_Rw,
    input  logic [DATA_W-1:0] WR_RegDin,
    input  logic              Flush,
    input  logic              Hold,
    output logic              Stall,
    output logic              EX_Valid,
    output logic [31:0]       EX_PC4,
    output logic [31:0]       EX_Jtarg,
    output logic [DATA_W-1:0] EX_busA,
    output logic [DATA_W-1:0] EX_busB,
    output logic [AW-1:0]     EX_Rs,
    output logic [AW-1:0]     EX_Rt,
    output logic [AW-1:0]     EX_Rd,
    output logic [5:0]        EX_func,
    output logic [15:0]       EX_immd,
    output logic [11:0]       EX_Ctrl
);
    logic [DATA_W-1:0] rf [2**AW];
    logic [AW-1:0]     rs, rt, rd;
    logic [11:0]       ctrl;
    logic [DATA_W-1:0] bus_a, bus_b;
    logic              wr_en, haz, bubble;

    assign rs = AW'(IDin_Inst[25:21]);
    assign rt = AW'(IDin_Inst[20:16]);
    assign rd = AW'(IDin_Inst[15:11]);

    // ctrl = {RegWr, ALUSrc, RegDst, MemtoReg, MemWr, Branch, Jump, ExtOp, R_type, ALUop[2:0]}
    always_comb begin
        ctrl = '0;
        if (IDin_Valid)
            case (IDin_Inst[31:26])
                6'b000000: ctrl = 12'b1010_0000_1111;
                6'b001001: ctrl = 12'b1100_0001_0000;
                6'b001101: ctrl = 12'b1100_0000_0010;
                6'b100011: ctrl = 12'b1101_0001_0000;
                6'b101011: ctrl = 12'b0100_1001_0000;
                6'b000100: ctrl = 12'b0000_0100_0001;
                6'b000010: ctrl = 12'b0000_0010_0000;
                default:   ctrl = '0;
            endcase
    end

    assign wr_en = WR_RegWE && (WR_Rw != '0);

    always_ff @(posedge Clk)
        if (wr_en) rf[WR_Rw] <= WR_RegDin;

    assign bus_a = (rs == '0) ? '0 :
                   ((BYPASS_EN != 0) && wr_en && (WR_Rw == rs)) ? WR_RegDin : rf[rs];
    assign bus_b = (rt == '0) ? '0 :
                   ((BYPASS_EN != 0) && wr_en && (WR_Rw == rt)) ? WR_RegDin : rf[rt];

    // EX_Ctrl[8] is MemtoReg: a load sitting in EX whose result ID needs now
    assign haz = (HAZARD_EN != 0) && IDin_Valid && EX_Valid && EX_Ctrl[8] &&
                 (EX_Rt != '0) && ((EX_Rt == rs) || (EX_Rt == rt));
    assign Stall = haz && !Flush && !Hold;

    // Hold outranks the hazard bubble, Flush outranks Hold
    assign bubble = Rst || Flush || (haz && !Hold);

    always_ff @(posedge Clk) begin
        if (bubble) begin
            EX_Valid <= 1'b0;
            EX_PC4   <= '0;
            EX_Jtarg <= '0;
            EX_busA  <= '0;
            EX_busB  <= '0;
            EX_Rs    <= '0;
            EX_Rt    <= '0;
            EX_Rd    <= '0;
            EX_func  <= '0;
            EX_immd  <= '0;
            EX_Ctrl  <= '0;
        end else if (!Hold) begin
            EX_Valid <= IDin_Valid;
            EX_PC4   <= IDin_PC4;
            EX_Jtarg <= {IDin_PC4[31:28], IDin_Inst[25:0], 2'b00};
            EX_busA  <= bus_a;
            EX_busB  <= bus_b;
            EX_Rs    <= rs;
            EX_Rt    <= rt;
            EX_Rd    <= rd;
            EX_func  <= IDin_Inst[5:0];
            EX_immd  <= IDin_Inst[15:0];
            EX_Ctrl  <= ctrl;
        end
    end
endmodule

// File: tb/tb_stage_id_pipe.sv
// tb_stage_id_pipe: scoreboard bench for stage_id_pipe (bypass and non-bypass instances)
module tb_stage_id_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, we, flush, hold;
    logic [31:0] pc4, inst, din;
    logic [4:0]  rw;

    logic        stall, ex_valid;
    logic [31:0] ex_pc4, ex_jtarg, ex_bus_a, ex_bus_b;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_func;
    logic [15:0] ex_immd;
    logic [11:0] ex_ctrl;

    logic        nb_stall, nb_valid;
    logic [31:0] nb_pc4, nb_jtarg, nb_bus_a, nb_bus_b;
    logic [4:0]  nb_rs, nb_rt, nb_rd;
    logic [5:0]  nb_func;
    logic [15:0] nb_immd;
    logic [11:0] nb_ctrl;

    stage_id_pipe dut (
        .Clk(clk), .Rst(rst), .IDin_PC4(pc4), .IDin_Inst(inst), .IDin_Valid(valid),
        .WR_RegWE(we), .WR_Rw(rw), .WR_RegDin(din), .Flush(flush), .Hold(hold),
        .Stall(stall), .EX_Valid(ex_valid), .EX_PC4(ex_pc4), .EX_Jtarg(ex_jtarg),
        .EX_busA(ex_bus_a), .EX_busB(ex_bus_b), .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_Rd(ex_rd),
        .EX_func(ex_func), .EX_immd(ex_immd), .EX_Ctrl(ex_ctrl)
    );

    stage_id_pipe #(.BYPASS_EN(0)) dut_nb (
        .Clk(clk), .Rst(rst), .IDin_PC4(pc4), .IDin_Inst(inst), .IDin_Valid(valid),
        .WR_RegWE(we), .WR_Rw(rw), .WR_RegDin(din), .Flush(flush), .Hold(hold),
        .Stall(nb_stall), .EX_Valid(nb_valid), .EX_PC4(nb_pc4), .EX_Jtarg(nb_jtarg),
        .EX_busA(nb_bus_a), .EX_busB(nb_bus_b), .EX_Rs(nb_rs), .EX_Rt(nb_rt), .EX_Rd(nb_rd),
        .EX_func(nb_func), .EX_immd(nb_immd), .EX_Ctrl(nb_ctrl)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4, jtarg, a, b, an, bn;
        logic        a_ok, b_ok, an_ok, bn_ok;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  func;
        logic [15:0] immd;
        logic [11:0] ctrl;
    } ex_t;

    ex_t         q[$];
    ex_t         m;
    logic [31:0] mrf [32];
    bit          mk [32];
    int          n_chk = 0, n_pass = 0;
    logic        last_stall;

    localparam logic [31:0] ADDIU_1_0_5 = 32'h2401_0005;
    localparam logic [31:0] ADDU_4_3_3  = 32'h0063_2021;
    localparam logic [31:0] ADDU_4_0_0  = 32'h0000_2021;
    localparam logic [31:0] LW_2_1      = 32'h8C22_0000;
    localparam logic [31:0] LW_0_1      = 32'h8C20_0000;
    localparam logic [31:0] ADDU_5_2_1  = 32'h0041_2821;
    localparam logic [31:0] ADDU_5_0_0  = 32'h0000_2821;
    localparam logic [31:0] J_100040    = 32'h0810_0040;
    localparam logic [31:0] BAD_OP      = 32'hFC00_0000;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [11:0] dec(input logic [5:0] op);
        case (op)
            6'b000000: return 12'hA0F;
            6'b001001: return 12'hC10;
            6'b001101: return 12'hC02;
            6'b100011: return 12'hD10;
            6'b101011: return 12'h490;
            6'b000100: return 12'h041;
            6'b000010: return 12'h020;
            default:   return 12'h000;
        endcase
    endfunction

    task automatic cyc(input logic r, input logic [31:0] i, input logic [31:0] p, input logic v,
                       input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic f, input logic h);
        ex_t n, e;
        logic [4:0] s, t;
        logic hz, hs, ht;
        rst = r; inst = i; pc4 = p; valid = v; we = w; rw = a; din = d; flush = f; hold = h;
        #1;
        s = i[25:21];
        t = i[20:16];
        hz = v && m.valid && m.ctrl[8] && (m.rt != 0) && (m.rt == s || m.rt == t);
        last_stall = stall;
        chk("stall", 64'(stall), 64'(hz && !f && !h));
        chk("stall_nb", 64'(nb_stall), 64'(hz && !f && !h));
        n = m;
        if (r || f || (hz && !h)) begin
            n = '0;
            {n.a_ok, n.b_ok, n.an_ok, n.bn_ok} = 4'hF;
        end else if (!h) begin
            hs = w && (a != 0) && (a == s);
            ht = w && (a != 0) && (a == t);
            n.valid = v;
            n.pc4   = p;
            n.jtarg = {p[31:28], i[25:0], 2'b00};
            n.a     = (s == 0) ? 32'h0 : hs ? d : mrf[s];
            n.b     = (t == 0) ? 32'h0 : ht ? d : mrf[t];
            n.an    = (s == 0) ? 32'h0 : mrf[s];
            n.bn    = (t == 0) ? 32'h0 : mrf[t];
            n.a_ok  = (s == 0) || hs || mk[s];
            n.b_ok  = (t == 0) || ht || mk[t];
            n.an_ok = (s == 0) || mk[s];
            n.bn_ok = (t == 0) || mk[t];
            n.rs    = s;
            n.rt    = t;
            n.rd    = i[15:11];
            n.func  = i[5:0];
            n.immd  = i[15:0];
            n.ctrl  = v ? dec(i[31:26]) : 12'h0;
        end
        m = n;
        q.push_back(n);
        @(posedge clk);
        if (w && a != 0) begin
            mrf[a] = d;
            mk[a]  = 1'b1;
        end
        @(negedge clk);
        e = q.pop_front();
        chk("ex_valid", 64'(ex_valid), 64'(e.valid));
        chk("ex_pc4", 64'(ex_pc4), 64'(e.pc4));
        chk("ex_jtarg", 64'(ex_jtarg), 64'(e.jtarg));
        chk("ex_rs", 64'(ex_rs), 64'(e.rs));
        chk("ex_rt", 64'(ex_rt), 64'(e.rt));
        chk("ex_rd", 64'(ex_rd), 64'(e.rd));
        chk("ex_func", 64'(ex_func), 64'(e.func));
        chk("ex_immd", 64'(ex_immd), 64'(e.immd));
        chk("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
        chk("nb_valid", 64'(nb_valid), 64'(e.valid));
        if (e.a_ok) chk("ex_bus_a", 64'(ex_bus_a), 64'(e.a));
        if (e.b_ok) chk("ex_bus_b", 64'(ex_bus_b), 64'(e.b));
        if (e.an_ok) chk("nb_bus_a", 64'(nb_bus_a), 64'(e.an));
        if (e.bn_ok) chk("nb_bus_b", 64'(nb_bus_b), 64'(e.bn));
    endtask

    initial begin
        logic [31:0] r, ri;
        logic [5:0]  op;
        logic [5:0]  ops [8];
        ops = '{6'b000000, 6'b001001, 6'b001101, 6'b100011,
                6'b101011, 6'b000100, 6'b000010, 6'b111111};
        for (int k = 0; k < 32; k++) begin
            mrf[k] = 32'h0;
            mk[k]  = (k == 0);
        end
        m = '0;
        {rst, valid, we, flush, hold} = 5'b10000;
        pc4 = 0; inst = 0; rw = 0; din = 0;
        @(posedge clk);
        @(negedge clk);

        cyc(1, ADDIU_1_0_5, 32'h4, 1, 1, 5'd1, 32'h100, 0, 0);
        chk("rst_valid", 64'(ex_valid), 64'h0);
        chk("rst_ctrl", 64'(ex_ctrl), 64'h0);
        cyc(1, ADDIU_1_0_5, 32'h4, 1, 1, 5'd2, 32'h200, 0, 0);
        cyc(0, ADDIU_1_0_5, 32'h4, 1, 0, 5'd0, 32'h0, 0, 0);
        chk("post_rst_ctrl", 64'(ex_ctrl), 64'hC10);
        chk("post_rst_immd", 64'(ex_immd), 64'h5);

        for (int k = 3; k < 32; k++)
            cyc(0, 32'h0, 32'h8, 0, 1, 5'(k), 32'h0101_0101 * 32'(k), 0, 0);

        cyc(0, ADDU_4_3_3, 32'h8, 1, 1, 5'd3, 32'hDEAD_BEEF, 0, 0);
        chk("byp_a", 64'(ex_bus_a), 64'hDEAD_BEEF);
        chk("byp_b", 64'(ex_bus_b), 64'hDEAD_BEEF);
        chk("nobyp_a", 64'(nb_bus_a), 64'h0303_0303);
        cyc(0, ADDU_4_0_0, 32'hC, 1, 1, 5'd0, 32'hFFFF_FFFF, 0, 0);
        chk("r0_write", 64'(ex_bus_a), 64'h0);

        cyc(0, LW_2_1, 32'h10, 1, 0, 5'd0, 32'h0, 0, 0);
        cyc(0, ADDU_5_2_1, 32'h14, 1, 1, 5'd2, 32'h2222_2222, 0, 0);
        chk("lu_stall", 64'(last_stall), 64'h1);
        chk("lu_bubble_v", 64'(ex_valid), 64'h0);
        chk("lu_bubble_c", 64'(ex_ctrl), 64'h0);
        cyc(0, ADDU_5_2_1, 32'h14, 1, 0, 5'd0, 32'h0, 0, 0);
        chk("lu_restall", 64'(last_stall), 64'h0);
        chk("lu_rs", 64'(ex_rs), 64'h2);
        chk("lu_rf_a", 64'(ex_bus_a), 64'h2222_2222);

        cyc(0, LW_0_1, 32'h18, 1, 0, 5'd0, 32'h0, 0, 0);
        cyc(0, ADDU_5_0_0, 32'h1C, 1, 0, 5'd0, 32'h0, 0, 0);
        chk("lw0_nostall", 64'(last_stall), 64'h0);
        chk("lw0_valid", 64'(ex_valid), 64'h1);

        cyc(0, LW_2_1, 32'h20, 1, 0, 5'd0, 32'h0, 0, 0);
        cyc(0, ADDU_5_2_1, 32'h24, 1, 0, 5'd0, 32'h0, 1, 0);
        chk("flush_stall", 64'(last_stall), 64'h0);
        chk("flush_valid", 64'(ex_valid), 64'h0);

        cyc(0, LW_2_1, 32'h28, 1, 0, 5'd0, 32'h0, 0, 0);
        cyc(0, ADDU_5_2_1, 32'h2C, 1, 0, 5'd0, 32'h0, 0, 1);
        chk("hold_stall", 64'(last_stall), 64'h0);
        chk("hold_ctrl", 64'(ex_ctrl), 64'hD10);
        chk("hold_pc4", 64'(ex_pc4), 64'h28);
        cyc(0, ADDU_5_2_1, 32'h2C, 1, 0, 5'd0, 32'h0, 0, 0);
        chk("unhold_stall", 64'(last_stall), 64'h1);
        cyc(0, ADDU_5_2_1, 32'h2C, 1, 0, 5'd0, 32'h0, 0, 0);

        cyc(0, LW_2_1, 32'h30, 1, 0, 5'd0, 32'h0, 0, 0);
        cyc(1, ADDU_5_2_1, 32'h34, 1, 0, 5'd0, 32'h0, 0, 0);
        cyc(0, ADDU_5_2_1, 32'h34, 1, 0, 5'd0, 32'h0, 0, 0);
        chk("rst_haz_stall", 64'(last_stall), 64'h0);

        cyc(0, J_100040, 32'h9000_0004, 1, 0, 5'd0, 32'h0, 0, 0);
        chk("j_targ", 64'(ex_jtarg), 64'h9040_0100);
        chk("j_jump", 64'(ex_ctrl[5]), 64'h1);
        cyc(0, BAD_OP, 32'h40, 1, 0, 5'd0, 32'h0, 0, 0);
        chk("bad_ctrl", 64'(ex_ctrl), 64'h0);
        chk("bad_valid", 64'(ex_valid), 64'h1);

        for (int k = 0; k < 300; k++) begin
            r  = $urandom;
            op = ops[$urandom_range(0, 7)];
            ri = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[15:0]};
            cyc($urandom_range(0, 24) == 0, ri, $urandom, $urandom_range(0, 5) != 0,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 4)), $urandom,
                $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
